// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller, decode and forwarding logic:
// FSM encoding, instruction field positions and the NOP encoding.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } hz_state_e;

    typedef logic [3:0] reg_idx_t;

    localparam int INST_W = 16;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/EX observations in,
// stall/flush/bubble controls and the perf counter out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      inst_curr_IDIF;
    logic             uses_rs_idif;
    logic             uses_rt_idif;
    logic [15:0]      inst_curr_IDEX;
    logic             lw_idex;
    logic             rf_wen_idex;
    logic             branch_taken_ex;
    logic             jal_idex;
    logic             jr_idex;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output inst_curr_IDIF, uses_rs_idif, uses_rt_idif, inst_curr_IDEX,
               lw_idex, rf_wen_idex, branch_taken_ex, jal_idex, jr_idex,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, busy, stall_cnt
    );

    modport slave (
        input  inst_curr_IDIF, uses_rs_idif, uses_rt_idif, inst_curr_IDEX,
               lw_idex, rf_wen_idex, branch_taken_ex, jal_idex, jr_idex,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Combinational load-use comparator: a load in ID/EX whose destination is a
// source read by the instruction in decode. Shared with the forwarding unit.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [INST_W-1:0] inst_idif,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [INST_W-1:0] inst_idex,
    input  logic              lw,
    input  logic              rf_wen,
    output logic              hz
);
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t dst;
    logic     unused_fields;

    assign rs  = inst_idif[RS_HI:RS_LO];
    assign rt  = inst_idif[RT_HI:RT_LO];
    assign dst = inst_idex[RD_HI:RD_LO];

    // R0 reads as zero, so a load targeting it never creates a dependency.
    assign hz = lw & rf_wen & (dst != 4'd0) &
                ((uses_rs & (rs == dst)) | (uses_rt & (rt == dst)));

    assign unused_fields = ^{inst_idif[INST_W-1:RS_HI+1],
                             inst_idex[INST_W-1:RD_HI+1],
                             inst_idex[RD_LO-1:0]};
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall and redirect flush sequencing,
// plus a saturating count of stall/flush cycles for performance debug.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int CNT_W             = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] LSTALL_REM = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FLUSH_REM  = 2'(FLUSH_CYCLES - 1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [1:0]       rem_q;
    logic [1:0]       rem_d;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hz_raw;
    logic             hz;
    logic             redir;
    logic             do_stall;
    logic             do_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_cmp u_cmp (
        .inst_idif (bus.inst_curr_IDIF),
        .uses_rs   (bus.uses_rs_idif),
        .uses_rt   (bus.uses_rt_idif),
        .inst_idex (bus.inst_curr_IDEX),
        .lw        (bus.lw_idex),
        .rf_wen    (bus.rf_wen_idex),
        .hz        (hz_raw)
    );

    // Inputs are ignored on the first cycle after reset release so that all
    // controls stay low until the pipeline registers hold valid contents.
    assign hz    = hz_raw & armed_q;
    assign redir = (bus.branch_taken_ex | bus.jal_idex | bus.jr_idex) & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 2'd0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            armed_q <= 1'b1;
            if (do_stall | do_flush)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        do_stall = 1'b0;
        do_flush = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redir) begin
                    do_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        rem_d   = FLUSH_REM;
                    end
                end else if (hz) begin
                    do_stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = ST_LSTALL;
                        rem_d   = LSTALL_REM;
                    end
                end
            end
            ST_LSTALL: begin
                if (redir) begin
                    do_flush = 1'b1;
                    state_d  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
                    rem_d    = (FLUSH_CYCLES > 1) ? FLUSH_REM : 2'd0;
                end else begin
                    do_stall = 1'b1;
                    if (rem_q <= 2'd1) begin
                        state_d = ST_IDLE;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
            end
            ST_FLUSH: begin
                // The decode instruction is being discarded, so hz is moot here.
                do_flush = 1'b1;
                if (redir) begin
                    rem_d = FLUSH_REM;
                end else if (rem_q <= 2'd1) begin
                    state_d = ST_IDLE;
                    rem_d   = 2'd0;
                end else begin
                    rem_d = rem_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = 2'd0;
            end
        endcase
    end

    assign bus.pc_stall   = do_stall;
    assign bus.ifid_stall = do_stall & ~do_flush;
    assign bus.ifid_flush = do_flush;
    assign bus.idex_stall = do_stall | do_flush;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a default instance and a LOAD_STALL_CYCLES=3,
// CNT_W=4 instance share the same stimulus; expectations are hand-scripted.
module tb_hazard_ctrl;

    localparam logic [4:0] C_IDLE  = 5'b00000; // {pc_stall,ifid_stall,ifid_flush,idex_stall,busy}
    localparam logic [4:0] C_STL0  = 5'b11010;
    localparam logic [4:0] C_STL1  = 5'b11011;
    localparam logic [4:0] C_FLS0  = 5'b00110;
    localparam logic [4:0] C_FLS1  = 5'b00111;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    hazard_ctrl_if #(.CNT_W(4))  bus_b ();

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  ctl_a;
        logic [15:0] cnt_a;
        logic [4:0]  ctl_b;
        logic [3:0]  cnt_b;
        bit          use_a;
        bit          use_b;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec;
    int          n_err;
    logic [15:0] cnt_a_m;
    logic [3:0]  cnt_b_m;

    function automatic logic [4:0] ctl_a_obs();
        return {bus_a.pc_stall, bus_a.ifid_stall, bus_a.ifid_flush, bus_a.idex_stall, bus_a.busy};
    endfunction

    function automatic logic [4:0] ctl_b_obs();
        return {bus_b.pc_stall, bus_b.ifid_stall, bus_b.ifid_flush, bus_b.idex_stall, bus_b.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] idif, input logic urs, input logic urt,
                          input logic [15:0] idex, input logic lw, input logic wen,
                          input logic br, input logic jal, input logic jr);
        bus_a.inst_curr_IDIF = idif;  bus_b.inst_curr_IDIF = idif;
        bus_a.uses_rs_idif   = urs;   bus_b.uses_rs_idif   = urs;
        bus_a.uses_rt_idif   = urt;   bus_b.uses_rt_idif   = urt;
        bus_a.inst_curr_IDEX = idex;  bus_b.inst_curr_IDEX = idex;
        bus_a.lw_idex        = lw;    bus_b.lw_idex        = lw;
        bus_a.rf_wen_idex    = wen;   bus_b.rf_wen_idex    = wen;
        bus_a.branch_taken_ex = br;   bus_b.branch_taken_ex = br;
        bus_a.jal_idex       = jal;   bus_b.jal_idex       = jal;
        bus_a.jr_idex        = jr;    bus_b.jr_idex        = jr;
    endtask

    task automatic clr_in();
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load to r3 in ID/EX, decode reads r3 through rs.
    task automatic hz_rs3();
        set_in(16'h0030, 1'b1, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock of stimulus: push the expectation, compare it mid-cycle.
    task automatic step(input string tag, input logic [4:0] ea, input logic [4:0] eb,
                        input bit ua, input bit ub);
        exp_t e;
        e.tag = tag; e.ctl_a = ea; e.cnt_a = cnt_a_m; e.ctl_b = eb; e.cnt_b = cnt_b_m;
        e.use_a = ua; e.use_b = ub;
        sbq.push_back(e);
        if (ea[4] | ea[2]) cnt_a_m = (&cnt_a_m) ? cnt_a_m : cnt_a_m + 16'd1;
        if (eb[4] | eb[2]) cnt_b_m = (&cnt_b_m) ? cnt_b_m : cnt_b_m + 4'd1;
        @(negedge clk);
        e = sbq.pop_front();
        if (e.use_a) begin
            chk({e.tag, ".ctl_a"}, 32'(ctl_a_obs()), 32'(e.ctl_a));
            chk({e.tag, ".cnt_a"}, 32'(bus_a.stall_cnt), 32'(e.cnt_a));
        end
        if (e.use_b) begin
            chk({e.tag, ".ctl_b"}, 32'(ctl_b_obs()), 32'(e.ctl_b));
            chk({e.tag, ".cnt_b"}, 32'(bus_b.stall_cnt), 32'(e.cnt_b));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        cnt_a_m = '0;
        cnt_b_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst_rel", C_IDLE, C_IDLE, 1'b1, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cnt_a_m = '0;
        cnt_b_m = '0;
        clr_in();
        rst_n = 1'b0;

        // Reset held 3 cycles with a live load-use on the inputs.
        hz_rs3();
        repeat (3) @(posedge clk);
        #1;
        chk("in_rst.ctl_a", 32'(ctl_a_obs()), 32'(C_IDLE));
        chk("in_rst.cnt_a", 32'(bus_a.stall_cnt), 32'd0);
        chk("in_rst.ctl_b", 32'(ctl_b_obs()), 32'(C_IDLE));
        rst_n = 1'b1;
        step("first_cyc", C_IDLE, C_IDLE, 1'b1, 1'b1);
        step("rel_hz",    C_STL0, C_STL0, 1'b1, 1'b1);
        clr_in();
        step("ls3_a", C_IDLE, C_STL1, 1'b1, 1'b1);
        step("ls3_b", C_IDLE, C_STL1, 1'b1, 1'b1);
        step("ls3_c", C_IDLE, C_IDLE, 1'b1, 1'b1);

        // Default instance: load-use via rs, then via rt.
        do_reset();
        hz_rs3();
        step("lu_rs", C_STL0, C_IDLE, 1'b1, 1'b0);
        clr_in();
        step("lu_rs_end", C_IDLE, C_IDLE, 1'b1, 1'b0);
        set_in(16'h0005, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rt", C_STL0, C_IDLE, 1'b1, 1'b0);
        set_in(16'h0005, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("no_lw", C_IDLE, C_IDLE, 1'b1, 1'b0);
        set_in(16'h0005, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_wen", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // R0 destination, and matching fields that are not read.
        set_in(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("r0", C_IDLE, C_IDLE, 1'b1, 1'b0);
        set_in(16'h0033, 1'b0, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("no_use", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // Taken-branch redirect: two flush cycles, PC never held.
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("br_0", C_FLS0, C_IDLE, 1'b1, 1'b0);
        clr_in();
        step("br_1", C_FLS1, C_IDLE, 1'b1, 1'b0);
        step("br_2", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // Hazard and jr together: redirect wins.
        hz_rs3();
        bus_a.jr_idex = 1'b1; bus_b.jr_idex = 1'b1;
        step("hzjr_0", C_FLS0, C_IDLE, 1'b1, 1'b0);
        clr_in();
        step("hzjr_1", C_FLS1, C_IDLE, 1'b1, 1'b0);
        step("hzjr_2", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // A jal during FLUSH restarts the flush window.
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rl_0", C_FLS0, C_IDLE, 1'b1, 1'b0);
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rl_1", C_FLS1, C_IDLE, 1'b1, 1'b0);
        clr_in();
        step("rl_2", C_FLS1, C_IDLE, 1'b1, 1'b0);
        step("rl_3", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // Hazard is ignored in FLUSH and honoured once back in IDLE.
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fhz_0", C_FLS0, C_IDLE, 1'b1, 1'b0);
        hz_rs3();
        step("fhz_1", C_FLS1, C_IDLE, 1'b1, 1'b0);
        step("fhz_2", C_STL0, C_IDLE, 1'b1, 1'b0);
        clr_in();
        step("fhz_3", C_IDLE, C_IDLE, 1'b1, 1'b0);

        // Three-cycle load stall aborted by a branch on its 2nd cycle.
        do_reset();
        hz_rs3();
        step("ab_0", C_IDLE, C_STL0, 1'b0, 1'b1);
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ab_1", C_IDLE, C_FLS1, 1'b0, 1'b1);
        clr_in();
        step("ab_2", C_IDLE, C_FLS1, 1'b0, 1'b1);
        step("ab_3", C_IDLE, C_IDLE, 1'b0, 1'b1);

        // Counter saturation on the 4-bit instance.
        do_reset();
        hz_rs3();
        for (int i = 0; i < 21; i++)
            step("sat_run", C_IDLE, (i % 3 == 0) ? C_STL0 : C_STL1, 1'b0, 1'b1);
        clr_in();
        step("sat_hold0", C_IDLE, C_IDLE, 1'b0, 1'b1);
        step("sat_hold1", C_IDLE, C_IDLE, 1'b0, 1'b1);
        chk("sat_val", 32'(bus_b.stall_cnt), 32'd15);

        // Asynchronous reset in the middle of FLUSH.
        do_reset();
        set_in(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mf_0", C_FLS0, C_IDLE, 1'b1, 1'b0);
        clr_in();
        #1;
        chk("mf_pre.ctl_a", 32'(ctl_a_obs()), 32'(C_FLS1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mf_rst.ctl_a", 32'(ctl_a_obs()), 32'(C_IDLE));
        chk("mf_rst.cnt_a", 32'(bus_a.stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_a_m = '0;
        cnt_b_m = '0;
        step("mf_rel", C_IDLE, C_IDLE, 1'b1, 1'b1);
        step("mf_idle", C_IDLE, C_IDLE, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It is the producer of the stall and bubble controls that the ID/EX pipeline register and the IF/ID stage consume.
- Watches the instruction held in ID/EX against the instruction decoding in IF/ID to detect load-use hazards. Watches EX-stage control transfers (taken branch, jal, jr) to flush wrong-path instructions.
- Drives PC hold, IF/ID hold/flush and ID/EX bubble insertion, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).
- FLUSH_CYCLES, 2, cycles of IF/ID flush plus ID/EX bubble after a redirect (1..3).
- CNT_W, 16, width of the stall/flush performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_curr_IDIF  in  16  instruction in decode; rs=[7:4], rt=[3:0].
- uses_rs_idif  in  1  decode reads rs.
- uses_rt_idif  in  1  decode reads rt.
- inst_curr_IDEX  in  16  instruction in ID/EX; destination=[11:8].
- lw_idex  in  1  ID/EX instruction is a load.
- rf_wen_idex  in  1  ID/EX instruction writes the register file.
- branch_taken_ex  in  1  EX resolved a taken branch this cycle.
- jal_idex  in  1  jal in EX.
- jr_idex  in  1  jr in EX.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  replace IF/ID contents with NOP.
- idex_stall  out  1  ID/EX bubble: load NOP controls (rf_wen=0, dmem_wen=0, branch=0, jal=0, jr=0).
- busy  out  1  state is not IDLE.
- stall_cnt  out  CNT_W  saturating count of cycles in which pc_stall or ifid_flush was asserted.

Behaviour:
States: IDLE, LSTALL, FLUSH. State is held in a 2-bit register plus a 2-bit down-counter `rem`.

Reset (rst_n=0, asynchronous):
- state=IDLE, rem=0, stall_cnt=0.
- All outputs are 0 while in reset and on the first cycle after release.

Decode signals (combinational):
- hz = lw_idex & rf_wen_idex & (dst!=0) & ((uses_rs_idif & rs==dst) | (uses_rt_idif & rt==dst)), where dst=inst_curr_IDEX[11:8].
- R0 is hardwired to zero and never creates a hazard.
- redir = branch_taken_ex | jal_idex | jr_idex.

Priority: redir > hz > hold current state.

IDLE:
- redir: ifid_flush=1, idex_stall=1 in the same cycle. If FLUSH_CYCLES>1, go to FLUSH with rem=FLUSH_CYCLES-1.
- else hz: pc_stall=1, ifid_stall=1, idex_stall=1 in the same cycle (zero-latency detect). If LOAD_STALL_CYCLES>1, go to LSTALL with rem=LOAD_STALL_CYCLES-1.
- else: all outputs 0.

LSTALL:
- Asserts pc_stall, ifid_stall, idex_stall.
- rem decrements each cycle; return to IDLE when rem reaches 1 on this cycle.
- A redir arriving in LSTALL aborts the stall: flush outputs that cycle, enter FLUSH (or IDLE if FLUSH_CYCLES==1).

FLUSH:
- Asserts ifid_flush, idex_stall; pc_stall=0, so the PC loads the redirect target.
- rem decrements each cycle; return to IDLE after the last cycle.
- A new redir during FLUSH reloads rem=FLUSH_CYCLES-1.
- hz is ignored in FLUSH, because the IF/ID instruction is being discarded.

Output rules:
- ifid_stall and ifid_flush are never both 1. Flush wins.
- busy = (state!=IDLE).

stall_cnt:
- Increments on each cycle with pc_stall|ifid_flush.
- Saturates at all-ones; no wrap.
- Cleared only by reset.

Reset asserted mid-LSTALL or mid-FLUSH: immediately IDLE, all outputs 0.

Decomposition:
- Shared package: state encoding (IDLE=0, LSTALL=1, FLUSH=2), instruction field positions (RS_HI/LO, RT_HI/LO, RD_HI/LO) and the NOP encoding 16'h0000. These are reused by the decode and forwarding logic.
- One natural sub-module: hazard_cmp, a purely combinational hz comparator, so the forwarding unit can reuse it. The FSM and counter stay in hazard_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with lw_idex=1, then deassert -> all outputs 0, stall_cnt=0, busy=0.
- Load-use: IDEX dst=3, lw=1, rf_wen=1; IDIF rs=3, uses_rs=1 -> pc_stall=ifid_stall=idex_stall=1 for exactly LOAD_STALL_CYCLES cycles (1 by default). The next cycle is all 0, and stall_cnt=1.
- R0 and no-use: IDEX dst=0, or uses_rs=uses_rt=0 with matching fields -> no stall over 10 cycles.
- Redirect: branch_taken_ex pulse for 1 cycle -> ifid_flush=idex_stall=1 for 2 cycles, pc_stall=0 throughout, then IDLE. stall_cnt increments by 2.
- Simultaneous: hz and jr_idex in the same cycle -> flush behaviour only, ifid_stall=0. A redir on the 2nd cycle of LSTALL with LOAD_STALL_CYCLES=3 aborts into FLUSH.
- Saturation: with CNT_W=4, force 20 stall cycles -> stall_cnt=15 and holds. Assert rst_n low mid-FLUSH -> outputs drop to 0 asynchronously.
